fp_div_sqrt_arbiter: RTL and testbench

Shares one FP div/sqrt unit between two issue requesters (two FP issue ports). Round-robin issue arbitration and an in-flight credit limit toward the unit. Results are routed back to the originating requester by an owner bit appended to the instruction id. Sits between the two FP issue stages and the unit's issue and writeback interfaces.

---
 rtl/fp_div_sqrt_arbiter.sv | 94 +++++++++
 tb/tb_fp_div_sqrt_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sqrt_arbiter.sv
// Shares one FP div/sqrt unit between two issue ports: round-robin issue grant,
// an in-flight credit limit toward the unit, and owner-tagged writeback routing.
module fp_div_sqrt_arbiter #(
  parameter int ID_W         = 3,
  parameter int MAX_INFLIGHT = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_sqrt,
  input  logic [31:0]     req_rs1_0,
  input  logic [31:0]     req_rs1_1,
  input  logic [31:0]     req_rs2_0,
  input  logic [31:0]     req_rs2_1,
  input  logic [ID_W-1:0] req_id_0,
  input  logic [ID_W-1:0] req_id_1,
  output logic            unit_new_request,
  input  logic            unit_ready,
  output logic            unit_sqrt,
  output logic [31:0]     unit_rs1,
  output logic [31:0]     unit_rs2,
  output logic [ID_W:0]   unit_id,
  input  logic            unit_wb_done,
  input  logic [ID_W:0]   unit_wb_id,
  input  logic [31:0]     unit_wb_rd,
  output logic            unit_wb_ack,
  output logic [1:0]      wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [31:0]     wb_rd,
  input  logic [1:0]      wb_ack
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  logic       last_grant_reg;
  logic [3:0] inflight_reg;
  logic [3:0] inflight_next;
  logic       any_valid;
  logic       both_valid;
  logic       grant;
  logic       can_issue;
  logic       owner;

  // A lone requester always wins; on a tie the one not served last time wins.
  always_comb begin
    any_valid  = |req_valid;
    both_valid = &req_valid;
    grant      = both_valid ? ~last_grant_reg : req_valid[1];
    can_issue  = unit_ready && (inflight_reg < MAX_CNT);
  end

  assign unit_new_request = can_issue && any_valid;

  // With no request, grant is 0, so the payload idles on requester 0.
  assign unit_sqrt = req_sqrt[grant];
  assign unit_rs1  = grant ? req_rs1_1 : req_rs1_0;
  assign unit_rs2  = grant ? req_rs2_1 : req_rs2_0;
  assign unit_id   = {grant, (grant ? req_id_1 : req_id_0)};

  assign owner       = unit_wb_id[ID_W];
  assign wb_id       = unit_wb_id[ID_W-1:0];
  assign wb_rd       = unit_wb_rd;
  assign unit_wb_ack = unit_wb_done && wb_ack[owner];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = can_issue && req_valid[gi] && (grant == 1'(gi));
      assign wb_done[gi]   = unit_wb_done && (owner == 1'(gi));
    end
  endgenerate

  // Simultaneous issue and acknowledge cancel; a credit freed at the limit is
  // only usable from the following cycle since can_issue looks at the register.
  always_comb begin
    inflight_next = inflight_reg;
    if (unit_new_request && !unit_wb_ack && (inflight_reg != MAX_CNT))
      inflight_next = inflight_reg + 4'd1;
    else if (unit_wb_ack && !unit_new_request && (inflight_reg != 4'd0))
      inflight_next = inflight_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      inflight_reg   <= 4'd0;
    end else begin
      if (unit_new_request)
        last_grant_reg <= grant;
      inflight_reg <= inflight_next;
    end
  end

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// Scoreboard bench for fp_div_sqrt_arbiter: a stimulus process pushes expected
// per-cycle outputs from a credit/round-robin model; a monitor pops and compares.
module tb_fp_div_sqrt_arbiter;

  localparam int ID_W = 3;
  localparam int MAXI = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_sqrt;
  logic [31:0]     req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
  logic [ID_W-1:0] req_id_0, req_id_1;
  logic            unit_new_request;
  logic            unit_ready;
  logic            unit_sqrt;
  logic [31:0]     unit_rs1, unit_rs2;
  logic [ID_W:0]   unit_id;
  logic            unit_wb_done;
  logic [ID_W:0]   unit_wb_id;
  logic [31:0]     unit_wb_rd;
  logic            unit_wb_ack;
  logic [1:0]      wb_done;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_rd;
  logic [1:0]      wb_ack;

  fp_div_sqrt_arbiter #(.ID_W(ID_W), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrt(req_sqrt),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
    .req_id_0(req_id_0), .req_id_1(req_id_1),
    .unit_new_request(unit_new_request), .unit_ready(unit_ready),
    .unit_sqrt(unit_sqrt), .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
    .unit_id(unit_id),
    .unit_wb_done(unit_wb_done), .unit_wb_id(unit_wb_id),
    .unit_wb_rd(unit_wb_rd), .unit_wb_ack(unit_wb_ack),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rdy;
    logic        nreq;
    logic        sqrt;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  uid;
    logic [1:0]  wbd;
    logic [2:0]  wid;
    logic [31:0] wrd;
    logic        uack;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   issues_seen = 0;
  int   cyc = 0;

  // Reference model state: credits in use and the requester served last.
  int credits;
  int prev_winner;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (unit_new_request) issues_seen++;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("req_ready", 32'(req_ready), 32'(e.rdy));
        check("unit_new_request", 32'(unit_new_request), 32'(e.nreq));
        check("wb_done", 32'(wb_done), 32'(e.wbd));
        check("unit_wb_ack", 32'(unit_wb_ack), 32'(e.uack));
        if (e.nreq) begin
          check("unit_sqrt", 32'(unit_sqrt), 32'(e.sqrt));
          check("unit_rs1", unit_rs1, e.rs1);
          check("unit_rs2", unit_rs2, e.rs2);
          check("unit_id", 32'(unit_id), 32'(e.uid));
        end
        if (e.wbd != 2'b00) begin
          check("wb_id", 32'(wb_id), 32'(e.wid));
          check("wb_rd", wb_rd, e.wrd);
        end
      end else if (unit_new_request || (wb_done != 2'b00)) begin
        check("unexpected_activity", {30'd0, unit_new_request, |wb_done}, 32'd0);
      end
    end
  end

  // One cycle: drive inputs, predict outputs, then advance the model at the edge.
  task automatic step(input logic [1:0] v, input logic rdy, input logic wd,
                      input logic [3:0] wid, input logic [1:0] ack);
    exp_t e;
    int   g;
    int   own;
    logic can;
    req_valid  = v;
    unit_ready = rdy;
    req_sqrt   = 2'($urandom);
    req_rs1_0  = $urandom; req_rs1_1 = $urandom;
    req_rs2_0  = $urandom; req_rs2_1 = $urandom;
    req_id_0   = 3'($urandom); req_id_1 = 3'($urandom);
    unit_wb_done = wd;
    unit_wb_id   = wid;
    unit_wb_rd   = $urandom;
    wb_ack       = ack;

    if (v == 2'b11) g = 1 - prev_winner;
    else if (v == 2'b10) g = 1;
    else g = 0;
    own    = int'(wid[3]);
    can    = rdy && (credits < MAXI);
    e.nreq = can && (v != 2'b00);
    e.rdy  = e.nreq ? 2'(1 << g) : 2'b00;
    e.sqrt = req_sqrt[g];
    e.rs1  = (g == 1) ? req_rs1_1 : req_rs1_0;
    e.rs2  = (g == 1) ? req_rs2_1 : req_rs2_0;
    e.uid  = {1'(g), ((g == 1) ? req_id_1 : req_id_0)};
    e.wbd  = wd ? 2'(1 << own) : 2'b00;
    e.wid  = wid[2:0];
    e.wrd  = unit_wb_rd;
    e.uack = wd && ack[own];
    exp_q.push_back(e);
    if (e.nreq || wd)
      $display("[TB] cyc %0d issue=%0d grant=%0d id=%0h wb=%0d owner=%0d ack=%0d credits=%0d",
               cyc, e.nreq, g, e.uid, wd, own, e.uack, credits);

    @(posedge clk);
    if (e.nreq) prev_winner = g;
    credits = credits + int'(e.nreq) - int'(e.uack);
    if (credits < 0) credits = 0;
    if (credits > MAXI) credits = MAXI;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00; unit_ready = 1'b0; unit_wb_done = 1'b0; wb_ack = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    credits = 0;
    prev_winner = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && credits > 0; i++)
      step(2'b00, 1'b1, 1'b1, 4'($urandom), 2'b11);
  endtask

  initial begin
    req_sqrt = 2'b00; req_rs1_0 = '0; req_rs1_1 = '0; req_rs2_0 = '0; req_rs2_1 = '0;
    req_id_0 = '0; req_id_1 = '0; unit_wb_id = '0; unit_wb_rd = '0;
    do_reset();

    // Both requesters hammering, no results: 12 alternating grants then stall.
    for (int i = 0; i < 14; i++) step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    // Owner-1 result acked at the limit; the freed credit is usable next cycle.
    step(2'b11, 1'b1, 1'b1, {1'b1, 3'd5}, 2'b10);
    check("issues_at_limit", 32'(issues_seen), 32'd12);
    step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    check("issues_after_free", 32'(issues_seen), 32'd13);
    drain();

    // Lone requester 1 for four cycles, then a tie must go to requester 0.
    for (int i = 0; i < 4; i++) step(2'b10, 1'b1, 1'b0, 4'd0, 2'b00);
    step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    // Reach 7 in flight, then issue and ack in the same cycle.
    step(2'b01, 1'b1, 1'b0, 4'd0, 2'b00);
    step(2'b01, 1'b1, 1'b1, {1'b0, 3'd2}, 2'b01);
    // Owner-0 result with only the non-owner acking is held, then accepted.
    step(2'b00, 1'b1, 1'b1, {1'b0, 3'd6}, 2'b10);
    step(2'b00, 1'b1, 1'b1, {1'b0, 3'd6}, 2'b01);
    // Unit stall with both valid, then resume in round-robin order.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 4'd0, 2'b00);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    drain();

    // Randomized traffic; results only while the model says something is in flight.
    for (int i = 0; i < 600; i++) begin
      logic wd;
      wd = (credits > 0) && ($urandom_range(0, 1) == 1);
      step(2'($urandom), ($urandom_range(0, 4) != 0), wd, 4'($urandom), 2'($urandom));
    end

    // Mid-run reset must clear the credit count and the tie-break.
    do_reset();
    for (int i = 0; i < 14; i++) step(2'b11, 1'b1, 1'b0, 4'd0, 2'b00);
    drain();
    for (int i = 0; i < 200; i++) begin
      logic wd;
      wd = (credits > 0) && ($urandom_range(0, 2) == 0);
      step(2'($urandom), 1'b1, wd, 4'($urandom), 2'($urandom));
    end

    @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
